// File: rtl/mux_selftest_pkg.sv
// Shared definitions for the 2:1 selector self-test drivers: state encoding,
// vector geometry and the golden selector function.
package mux_selftest_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_DRIVE  = 2'd1;
    localparam logic [1:0] STATE_SAMPLE = 2'd2;
    localparam logic [1:0] STATE_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = STATE_IDLE,
        S_DRIVE  = STATE_DRIVE,
        S_SAMPLE = STATE_SAMPLE,
        S_DONE   = STATE_DONE
    } state_t;

    localparam int VEC_WIDTH   = 3;
    localparam int NUM_VECTORS = 8;

    // Vector layout is {sel, in1, in2}.
    function automatic logic exp_mux(input logic [VEC_WIDTH-1:0] vec);
        return vec[2] ? vec[1] : vec[0];
    endfunction

endpackage

// File: rtl/mux_selftest_driver_settle_counter.sv
// Loadable down-counter that flags when a hold period of COUNT cycles has
// elapsed; the load cycle itself counts as the first held cycle.
module settle_counter #(
    parameter int COUNT = 1
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Load,
    input  logic i_Enable,
    output logic o_Expired
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CW-1:0] r_Count;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Count <= '0;
        end else if (i_Load) begin
            r_Count <= CW'(COUNT - 1);
        end else if (i_Enable && (r_Count != '0)) begin
            r_Count <= r_Count - 1'b1;
        end
    end

    assign o_Expired = (r_Count == '0);

endmodule

// File: rtl/mux_selftest_driver.sv
// Stimulus/checker for a 2:1 selector: sweeps all {sel,in1,in2} vectors for
// NUM_PASSES passes and reports error count and first failing vector.
module mux_selftest_driver
    import mux_selftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 2,
    parameter int ERR_WIDTH     = 8
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Start,
    input  logic                 i_Abort,
    input  logic                 i_MuxOutput,
    output logic                 o_Input1,
    output logic                 o_Input2,
    output logic                 o_Selector,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Pass,
    output logic [ERR_WIDTH-1:0] o_ErrCount,
    output logic [2:0]           o_FirstFail
);

    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    state_t                 r_State;
    state_t                 w_NextState;
    logic [VEC_WIDTH-1:0]   r_Vec;
    logic [PW-1:0]          r_PassCnt;
    logic [ERR_WIDTH-1:0]   r_ErrCount;
    logic [VEC_WIDTH-1:0]   r_FirstFail;
    logic                   w_Expired;
    logic                   w_Load;
    logic                   w_Accept;
    logic                   w_Wrap;
    logic                   w_LastPass;
    logic                   w_Mismatch;

    settle_counter #(
        .COUNT (SETTLE_CYCLES)
    ) u_settle (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Load    (w_Load),
        .i_Enable  (r_State == S_DRIVE),
        .o_Expired (w_Expired)
    );

    assign w_Accept   = i_Start && !i_Abort && ((r_State == S_IDLE) || (r_State == S_DONE));
    assign w_Wrap     = (r_Vec == VEC_WIDTH'(NUM_VECTORS - 1));
    assign w_LastPass = (r_PassCnt == PW'(NUM_PASSES - 1));
    assign w_Mismatch = (r_State == S_SAMPLE) && !i_Abort && (i_MuxOutput != exp_mux(r_Vec));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            S_IDLE:   if (w_Accept) w_NextState = S_DRIVE;
            S_DRIVE:  begin
                if (i_Abort)        w_NextState = S_IDLE;
                else if (w_Expired) w_NextState = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (i_Abort)                    w_NextState = S_IDLE;
                else if (w_Wrap && w_LastPass)  w_NextState = S_DONE;
                else                            w_NextState = S_DRIVE;
            end
            S_DONE:   begin
                if (i_Abort)       w_NextState = S_IDLE;
                else if (w_Accept) w_NextState = S_DRIVE;
            end
            default:  w_NextState = S_IDLE;
        endcase
    end

    // Settle period restarts on every entry into DRIVE.
    assign w_Load = (w_NextState == S_DRIVE) && (r_State != S_DRIVE);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Vec       <= '0;
            r_PassCnt   <= '0;
            r_ErrCount  <= '0;
            r_FirstFail <= '0;
        end else if (i_Abort) begin
            r_Vec     <= '0;
            r_PassCnt <= '0;
        end else if (w_Accept) begin
            r_Vec       <= '0;
            r_PassCnt   <= '0;
            r_ErrCount  <= '0;
            r_FirstFail <= '0;
        end else if (r_State == S_SAMPLE) begin
            if (w_Mismatch) begin
                if (r_ErrCount != {ERR_WIDTH{1'b1}}) begin
                    r_ErrCount <= r_ErrCount + 1'b1;
                end
                // A zero count means no earlier mismatch this run.
                if (r_ErrCount == '0) begin
                    r_FirstFail <= r_Vec;
                end
            end
            r_Vec <= r_Vec + 1'b1;
            if (w_Wrap) begin
                r_PassCnt <= w_LastPass ? '0 : r_PassCnt + 1'b1;
            end
        end
    end

    assign o_Selector  = r_Vec[2];
    assign o_Input1    = r_Vec[1];
    assign o_Input2    = r_Vec[0];
    assign o_Busy      = (r_State == S_DRIVE) || (r_State == S_SAMPLE);
    assign o_Done      = (r_State == S_DONE);
    assign o_Pass      = (r_State == S_DONE) && (r_ErrCount == '0);
    assign o_ErrCount  = r_ErrCount;
    assign o_FirstFail = r_FirstFail;

endmodule

// File: tb/tb_mux_selftest_driver.sv
// Bench for mux_selftest_driver: selector models are 8-entry truth tables,
// results are predicted by sweeping the vector list in plain arithmetic.
module tb_mux_selftest_driver;

    logic clk;
    logic rst_n;

    logic       start1, abort1;
    logic [7:0] tt1;
    logic       mux1, in1_1, in2_1, sel_1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [2:0] first1;

    logic       start2, abort2;
    logic [7:0] tt2;
    logic       mux2, in1_2, in2_2, sel_2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [2:0] first2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] TT_IDEAL  = 8'b1100_1010;
    localparam logic [7:0] TT_STUCK0 = 8'b0000_0000;
    localparam logic [7:0] TT_NOSEL  = 8'b1010_1010;

    assign mux1 = tt1[{sel_1, in1_1, in2_1}];
    assign mux2 = tt2[{sel_2, in1_2, in2_2}];

    mux_selftest_driver #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .ERR_WIDTH(8)) dut1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start1), .i_Abort(abort1),
        .i_MuxOutput(mux1), .o_Input1(in1_1), .o_Input2(in2_1), .o_Selector(sel_1),
        .o_Busy(busy1), .o_Done(done1), .o_Pass(pass1), .o_ErrCount(err1),
        .o_FirstFail(first1)
    );

    mux_selftest_driver #(.SETTLE_CYCLES(3), .NUM_PASSES(1), .ERR_WIDTH(2)) dut2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start2), .i_Abort(abort2),
        .i_MuxOutput(mux2), .o_Input1(in1_2), .o_Input2(in2_2), .o_Selector(sel_2),
        .o_Busy(busy2), .o_Done(done2), .o_Pass(pass2), .o_ErrCount(err2),
        .o_FirstFail(first2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the first nvec vectors of the sweep, count mismatches
    // against the ideal selector, saturate at maxerr, remember the first.
    task automatic model(input logic [7:0] tt, input int nvec, input int maxerr,
                         output int errs, output int first);
        bit seen;
        errs  = 0;
        first = 0;
        seen  = 0;
        for (int i = 0; i < nvec; i++) begin
            int v, exp_bit;
            v       = i % 8;
            exp_bit = ((v >> 2) & 1) ? ((v >> 1) & 1) : (v & 1);
            if (int'(tt[v]) != exp_bit) begin
                if (!seen) first = v;
                seen = 1;
                if (errs < maxerr) errs++;
            end
        end
    endtask

    // Full run on dut1 (settle 1, 2 passes): per-cycle busy/vector checks,
    // then run length and results against the model.
    task automatic run1(input logic [7:0] tt, input int hold, input string name);
        int cycles, exp_err, exp_first;
        model(tt, 16, 255, exp_err, exp_first);
        tt1 = tt;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        if (hold <= 1) start1 = 1'b0;
        check({name, "_err_cleared"}, err1, 0);
        check({name, "_first_cleared"}, first1, 0);
        cycles = 0;
        while (done1 !== 1'b1 && cycles < 200) begin
            check({name, "_busy"}, busy1, 1);
            check({name, "_vector"}, {sel_1, in1_1, in2_1}, (cycles / 2) % 8);
            @(posedge clk); #1;
            cycles++;
            if (cycles >= hold - 1) start1 = 1'b0;
        end
        check({name, "_run_length"}, cycles, 32);
        check({name, "_busy_done"}, busy1, 0);
        check({name, "_errcount"}, err1, exp_err);
        check({name, "_firstfail"}, first1, exp_first);
        check({name, "_pass"}, pass1, (exp_err == 0) ? 1 : 0);
        $display("run %s tt=%b cycles=%0d err=%0d first=%0d pass=%0d",
                 name, tt, cycles, err1, first1, pass1);
    endtask

    initial begin
        int cycles, exp_err, exp_first;
        rst_n  = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; tt1 = TT_IDEAL;
        start2 = 1'b0; abort2 = 1'b0; tt2 = TT_STUCK0;
        #23;
        check("reset_busy", busy1, 0);
        check("reset_done", done1, 0);
        check("reset_pass", pass1, 0);
        check("reset_drive", {sel_1, in1_1, in2_1}, 0);
        check("reset_err", err1, 0);
        check("reset_first", first1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run1(TT_IDEAL,  1, "ideal");
        run1(TT_STUCK0, 1, "stuck0");
        run1(TT_NOSEL,  1, "nosel");
        for (int r = 0; r < 4; r++) begin
            run1(8'($urandom), (r == 2) ? 5 : 1, "random");
        end

        // Abort mid-run: drivers idle, results kept for debug.
        tt1 = TT_STUCK0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        model(TT_STUCK0, 5, 255, exp_err, exp_first);
        check("abort_busy", busy1, 0);
        check("abort_done", done1, 0);
        check("abort_drive", {sel_1, in1_1, in2_1}, 0);
        check("abort_err_kept", err1, exp_err);
        check("abort_first_kept", first1, exp_first);
        $display("abort err=%0d first=%0d", err1, first1);
        @(posedge clk); #1;
        check("abort_stays_idle", busy1, 0);
        run1(TT_IDEAL, 1, "after_abort");

        // Asynchronous reset between edges while in DRIVE.
        tt1 = TT_STUCK0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("prereset_drive", {sel_1, in1_1, in2_1}, 2);
        check("prereset_err", err1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_busy", busy1, 0);
        check("areset_drive", {sel_1, in1_1, in2_1}, 0);
        check("areset_err", err1, 0);
        check("areset_first", first1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("postreset_busy", busy1, 0);
        check("postreset_done", done1, 0);
        check("postreset_drive", {sel_1, in1_1, in2_1}, 0);
        $display("async reset mid-drive recovered busy=%0d done=%0d", busy1, done1);

        // Narrow counter, longer settle, single pass: saturation.
        model(TT_STUCK0, 8, 3, exp_err, exp_first);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cycles = 0;
        while (done2 !== 1'b1 && cycles < 200) begin
            check("sat_vector", {sel_2, in1_2, in2_2}, (cycles / 4) % 8);
            @(posedge clk); #1;
            cycles++;
        end
        check("sat_run_length", cycles, 32);
        check("sat_errcount", err2, exp_err);
        check("sat_firstfail", first2, exp_first);
        check("sat_pass", pass2, 0);
        $display("saturation run cycles=%0d err=%0d first=%0d", cycles, err2, first2);

        @(negedge clk);
        start2 = 1'b1;
        abort2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        abort2 = 1'b0;
        check("startabort_done", done2, 0);
        check("startabort_busy", busy2, 0);
        check("startabort_err_kept", err2, exp_err);
        $display("start+abort in DONE: done=%0d busy=%0d", done2, busy2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
